// File: rtl/axi_pkg.sv
// Shared types, widths and the byte-strobe merge helper for the AXI SRAM responder.
package axi_pkg;

    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_STRB_W = 8;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_WRITE = 2'd1,
        W_RESP  = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    // Take byte i from new_word when strb[i] is set, otherwise keep old_word.
    function automatic logic [AXI_DATA_W-1:0] strb_merge(
        input logic [AXI_DATA_W-1:0] old_word,
        input logic [AXI_DATA_W-1:0] new_word,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < AXI_STRB_W; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_1r1w_strb.sv
// DEPTH x 64-bit storage with a byte-enabled write port and a combinational read port.
// Contents are deliberately not reset.
module sram_1r1w_strb
    import axi_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [AXI_STRB_W-1:0] wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [AXI_DATA_W-1:0] rdata
);

    logic [AXI_DATA_W-1:0] mem [DEPTH];

    // Byte-granular write: only strobed lanes are updated.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < AXI_STRB_W; i++) begin
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_sram_responder.sv
// Single-beat AXI responder backed by a byte-strobed SRAM.
// Independent write (AW/W/B) and read (AR/R) engines; read latency set by READ_LAT.
// Optional macro AXI_RESP_STALL_EN: a 16-bit LFSR randomly forces AW/W/AR READY low.
//
// Handshake rule: a channel transfers on a cycle where VALID & READY are both 1.
// B_VALID/R_VALID and R_DATA stay stable from assertion until the matching READY.
module axi_sram_responder
    import axi_pkg::*;
#(
    parameter int                    MEM_DEPTH = 4096,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 64'h8000_0000,
    parameter int                    READ_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_ADDR_W-1:0] axi_AW_ADDR,
    input  logic                  axi_AW_VALID,
    output logic                  axi_AW_READY,
    input  logic [AXI_DATA_W-1:0] axi_W_DATA,
    input  logic [AXI_STRB_W-1:0] axi_W_STRB,
    input  logic                  axi_W_VALID,
    output logic                  axi_W_READY,
    output logic                  axi_B_VALID,
    input  logic                  axi_B_READY,
    input  logic [AXI_ADDR_W-1:0] axi_AR_ADDR,
    input  logic                  axi_AR_VALID,
    output logic                  axi_AR_READY,
    output logic [AXI_DATA_W-1:0] axi_R_DATA,
    output logic                  axi_R_VALID,
    input  logic                  axi_R_READY
);

    localparam int                    IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AXI_ADDR_W-1:0] MEM_BYTES = 64'(MEM_DEPTH) << 3;

    wr_state_t             wr_state;
    rd_state_t             rd_state;
    logic                  aw_got, w_got;
    logic [AXI_ADDR_W-1:0] aw_addr_q;
    logic [AXI_DATA_W-1:0] wdata_q;
    logic [AXI_STRB_W-1:0] wstrb_q;
    logic [AXI_ADDR_W-1:0] ar_addr_q;
    logic [3:0]            rd_cnt;
    logic                  stall;

`ifdef AXI_RESP_STALL_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) used as a backpressure source.
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    assign axi_AW_READY = ~rst & ~stall & (wr_state == W_IDLE) & ~aw_got;
    assign axi_W_READY  = ~rst & ~stall & (wr_state == W_IDLE) & ~w_got;
    assign axi_AR_READY = ~rst & ~stall & (rd_state == R_IDLE);

    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = axi_AW_VALID & axi_AW_READY;
    assign w_hs  = axi_W_VALID  & axi_W_READY;
    assign ar_hs = axi_AR_VALID & axi_AR_READY;

    // Address decode for the latched write and for the read about to be sampled.
    // In R_IDLE the sample (READ_LAT==1) uses the address on the bus this cycle.
    logic [AXI_ADDR_W-1:0] wr_off, rd_addr, rd_off;
    logic                  wr_in_range, rd_in_range;
    logic [IDX_W-1:0]      wr_idx, rd_idx;

    assign wr_off      = aw_addr_q - BASE_ADDR;
    assign wr_in_range = (aw_addr_q >= BASE_ADDR) && (wr_off < MEM_BYTES);
    assign wr_idx      = wr_off[IDX_W+2:3];
    assign rd_addr     = (rd_state == R_IDLE) ? axi_AR_ADDR : ar_addr_q;
    assign rd_off      = rd_addr - BASE_ADDR;
    assign rd_in_range = (rd_addr >= BASE_ADDR) && (rd_off < MEM_BYTES);
    assign rd_idx      = rd_off[IDX_W+2:3];

    logic                  mem_we;
    logic [AXI_DATA_W-1:0] mem_rdata, rd_word;

    assign mem_we = (wr_state == W_WRITE) && wr_in_range;

    sram_1r1w_strb #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_idx),
        .wdata (wdata_q),
        .wstrb (wstrb_q),
        .raddr (rd_idx),
        .rdata (mem_rdata)
    );

    // A read sampled in the same cycle as a write to the same word sees the new bytes.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (mem_we && (wr_idx == rd_idx)) rd_word = strb_merge(mem_rdata, wdata_q, wstrb_q);
            else                              rd_word = mem_rdata;
        end
    end

    // Write engine: collect AW and W in any order, commit, then hold B until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state    <= W_IDLE;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            axi_B_VALID <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= axi_AW_ADDR;
                        aw_got    <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q <= axi_W_DATA;
                        wstrb_q <= axi_W_STRB;
                        w_got   <= 1'b1;
                    end
                    if ((aw_got | aw_hs) && (w_got | w_hs)) wr_state <= W_WRITE;
                end
                W_WRITE: begin
                    aw_got      <= 1'b0;
                    w_got       <= 1'b0;
                    axi_B_VALID <= 1'b1;
                    wr_state    <= W_RESP;
                end
                W_RESP: begin
                    if (axi_B_READY) begin
                        axi_B_VALID <= 1'b0;
                        wr_state    <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read engine: count down the programmed latency, sample data on entry to R_RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state    <= R_IDLE;
            rd_cnt      <= 4'd0;
            axi_R_VALID <= 1'b0;
            axi_R_DATA  <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        ar_addr_q <= axi_AR_ADDR;
                        rd_cnt    <= 4'(READ_LAT - 1);
                        if (READ_LAT == 1) begin
                            axi_R_VALID <= 1'b1;
                            axi_R_DATA  <= rd_word;
                            rd_state    <= R_RESP;
                        end else begin
                            rd_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (rd_cnt == 4'd1) begin
                        axi_R_VALID <= 1'b1;
                        axi_R_DATA  <= rd_word;
                        rd_state    <= R_RESP;
                    end else begin
                        rd_cnt <= rd_cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (axi_R_READY) begin
                        axi_R_VALID <= 1'b0;
                        rd_state    <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule
